exe_stage_mc: RTL and testbench

Parametrised multi-cycle execute stage for the ARM-subset pipeline. It extends the single-cycle execute datapath (forwarding muxes, Val2 generation, ALU, branch adder, status register) with three additions:
- a registered EXE/MEM output boundary;
- a valid/ready handshake;
- an iterative shift-add multiplier for MUL, which stalls the upstream pipeline while busy.

It sits between the ID/EXE register and the MEM stage.

---
 rtl/exe_pkg.sv | 32 +++
 rtl/iter_mul.sv | 59 +++++
 rtl/exe_stage_mc.sv | 242 ++++++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared constants and FSM state type for the multi-cycle execute stage.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_MLA = 4'b1011;

    localparam int unsigned ST_N = 3;
    localparam int unsigned ST_Z = 2;
    localparam int unsigned ST_C = 1;
    localparam int unsigned ST_V = 0;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } exeState_e;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; low N bits of the product.
// 'last' is high during the final iteration, 'done' pulses once the product is complete.
module iter_mul #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic         last,
    output logic         done,
    output logic [N-1:0] product
);

    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            last    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= '0;
                mcand   <= multiplicand;
                mplier  <= multiplier;
                cnt     <= '0;
                busy    <= 1'b1;
                last    <= 1'b0;
            end else if (busy) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                // flag the iteration that runs with cnt == N-1
                last   <= (cnt == CNT_W'(N - 2));
                if (last) begin
                    busy <= 1'b0;
                    last <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: forwarding, Val2, ALU, branch adder, status and an iterative MUL.
// Define EXE_MLA_EN to make exeCmd 1011 perform MLA (product + forwarded source 1).
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    output logic         inReady,
    input  logic         flush,
    input  logic         wbEnIn,
    input  logic         memREnIn,
    input  logic         memWEnIn,
    input  logic         ldStatus,
    input  logic         imm,
    input  logic [3:0]   exeCmd,
    input  logic [N-1:0] val1,
    input  logic [N-1:0] valRm,
    input  logic [N-1:0] pc,
    input  logic [11:0]  shifterOperand,
    input  logic [23:0]  signedImm24,
    input  logic [3:0]   dest,
    input  logic [1:0]   selSrc1,
    input  logic [1:0]   selSrc2,
    input  logic [N-1:0] valMem,
    input  logic [N-1:0] valWb,
    output logic         outValid,
    output logic         wbEnOut,
    output logic         memREnOut,
    output logic         memWEnOut,
    output logic [N-1:0] aluRes,
    output logic [N-1:0] exeValRm,
    output logic [N-1:0] branchAddr,
    output logic [3:0]   exeDest,
    output logic [3:0]   status
);

    function automatic logic [N-1:0] fwdSel(input logic [1:0] sel, input logic [N-1:0] r,
                                            input logic [N-1:0] m, input logic [N-1:0] w);
        case (sel)
            2'b00:   return r;
            2'b01:   return m;
            2'b10:   return w;
            default: return '0;
        endcase
    endfunction

    function automatic logic [N-1:0] rorN(input logic [N-1:0] x, input logic [4:0] amt);
        int unsigned a;
        a = 32'(amt) % N;
        if (a == 0) return x;
        return (x >> a) | (x << (N - a));
    endfunction

    exeState_e    state;
    logic [N-1:0] src1, rmFwd, val2, brAddr, aluOut;
    logic [N:0]   sum;
    logic [3:0]   aluFlags;
    logic         aluLd;
    logic         isMulCmd, mulStart, mulLast, mulDone;
    logic [N-1:0] mulA, mulProduct, mulResult;
    logic         wbLat, memRLat, memWLat, ldLat;
    logic [3:0]   destLat;
    logic [N-1:0] rmLat, brLat;

    assign src1   = fwdSel(selSrc1, val1, valMem, valWb);
    assign rmFwd  = fwdSel(selSrc2, valRm, valMem, valWb);
    assign brAddr = pc + N'($signed({signedImm24, 2'b00}));

    // Val2: memory offset, rotated immediate, or shifted Rm
    always_comb begin
        val2 = '0;
        if (memREnIn || memWEnIn) begin
            val2 = N'($signed(shifterOperand));
        end else if (imm) begin
            val2 = rorN(N'(shifterOperand[7:0]), {shifterOperand[11:8], 1'b0});
        end else begin
            case (shifterOperand[6:5])
                SH_LSL:  val2 = rmFwd << shifterOperand[11:7];
                SH_LSR:  val2 = rmFwd >> shifterOperand[11:7];
                SH_ASR:  val2 = N'($signed(rmFwd) >>> shifterOperand[11:7]);
                default: val2 = rorN(rmFwd, shifterOperand[11:7]);
            endcase
        end
    end

    always_comb begin
        aluOut   = '0;
        sum      = '0;
        aluFlags = status;
        aluLd    = 1'b1;
        case (exeCmd)
            CMD_MOV: aluOut = val2;
            CMD_MVN: aluOut = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, src1} + {1'b0, val2}
                    + ((exeCmd == CMD_ADC) ? (N+1)'(status[ST_C]) : '0);
                aluOut         = sum[N-1:0];
                aluFlags[ST_C] = sum[N];
                aluFlags[ST_V] = (src1[N-1] == val2[N-1]) && (aluOut[N-1] != src1[N-1]);
            end
            CMD_SUB, CMD_SBC: begin
                // carry out of a + ~b + cin is ARM's not-borrow
                sum = {1'b0, src1} + {1'b0, ~val2}
                    + ((exeCmd == CMD_SUB) ? (N+1)'(1) : (N+1)'(status[ST_C]));
                aluOut         = sum[N-1:0];
                aluFlags[ST_C] = sum[N];
                aluFlags[ST_V] = (src1[N-1] != val2[N-1]) && (aluOut[N-1] != src1[N-1]);
            end
            CMD_AND: aluOut = src1 & val2;
            CMD_ORR: aluOut = src1 | val2;
            CMD_EOR: aluOut = src1 ^ val2;
            default: aluLd = 1'b0;
        endcase
        aluFlags[ST_N] = aluOut[N-1];
        aluFlags[ST_Z] = (aluOut == '0);
    end

    assign mulStart = (state == S_IDLE) && inValid && isMulCmd && !flush;

    // MUL multiplies source 1 by Val2; MLA multiplies Rm by Val2 and adds source 1
`ifdef EXE_MLA_EN
    logic         mlaLat;
    logic [N-1:0] src1Lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            mlaLat  <= 1'b0;
            src1Lat <= '0;
        end else if (mulStart) begin
            mlaLat  <= (exeCmd == CMD_MLA);
            src1Lat <= src1;
        end
    end

    assign isMulCmd  = (exeCmd == CMD_MUL) || (exeCmd == CMD_MLA);
    assign mulA      = (exeCmd == CMD_MLA) ? rmFwd : src1;
    assign mulResult = mlaLat ? (mulProduct + src1Lat) : mulProduct;
`else
    assign isMulCmd  = (exeCmd == CMD_MUL);
    assign mulA      = src1;
    assign mulResult = mulProduct;
`endif

    iter_mul #(.N(N), .CNT_W(CNT_W)) uMul (
        .clk          (clk),
        .rst          (rst),
        .start        (mulStart),
        .abort        (flush),
        .multiplicand (mulA),
        .multiplier   (val2),
        .last         (mulLast),
        .done         (mulDone),
        .product      (mulProduct)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            inReady    <= 1'b1;
            outValid   <= 1'b0;
            wbEnOut    <= 1'b0;
            memREnOut  <= 1'b0;
            memWEnOut  <= 1'b0;
            aluRes     <= '0;
            exeValRm   <= '0;
            branchAddr <= '0;
            exeDest    <= '0;
            status     <= '0;
            wbLat      <= 1'b0;
            memRLat    <= 1'b0;
            memWLat    <= 1'b0;
            ldLat      <= 1'b0;
            destLat    <= '0;
            rmLat      <= '0;
            brLat      <= '0;
        end else if (flush) begin
            state    <= S_IDLE;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inValid && isMulCmd) begin
                        state   <= S_MUL;
                        inReady <= 1'b0;
                        wbLat   <= wbEnIn;
                        memRLat <= memREnIn;
                        memWLat <= memWEnIn;
                        ldLat   <= ldStatus;
                        destLat <= dest;
                        rmLat   <= rmFwd;
                        brLat   <= brAddr;
                    end else if (inValid) begin
                        outValid   <= 1'b1;
                        wbEnOut    <= wbEnIn;
                        memREnOut  <= memREnIn;
                        memWEnOut  <= memWEnIn;
                        aluRes     <= aluOut;
                        exeValRm   <= rmFwd;
                        branchAddr <= brAddr;
                        exeDest    <= dest;
                        if (ldStatus && aluLd) begin
                            status <= aluFlags;
                        end
                    end
                end
                S_MUL: begin
                    if (mulLast) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (mulDone) begin
                        state      <= S_IDLE;
                        inReady    <= 1'b1;
                        outValid   <= 1'b1;
                        wbEnOut    <= wbLat;
                        memREnOut  <= memRLat;
                        memWEnOut  <= memWLat;
                        aluRes     <= mulResult;
                        exeValRm   <= rmLat;
                        branchAddr <= brLat;
                        exeDest    <= destLat;
                        if (ldLat) begin
                            status <= {mulResult[N-1], (mulResult == '0), status[ST_C], status[ST_V]};
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    inReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: directed cases plus randomized instructions against a reference model.
module tb_exe_stage_mc;

    localparam int unsigned N = 32;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic        flush;
    logic        wbEnIn, memREnIn, memWEnIn, ldStatus, imm;
    logic [3:0]  exeCmd;
    logic [31:0] val1, valRm, pc;
    logic [11:0] shifterOperand;
    logic [23:0] signedImm24;
    logic [3:0]  dest;
    logic [1:0]  selSrc1, selSrc2;
    logic [31:0] valMem, valWb;
    logic        outValid, wbEnOut, memREnOut, memWEnOut;
    logic [31:0] aluRes, exeValRm, branchAddr;
    logic [3:0]  exeDest;
    logic [3:0]  status;

    int          assertCnt = 0;
    int          failCnt   = 0;
    logic [3:0]  expStatus;
    logic [31:0] lastRes;

    exe_stage_mc #(.N(N)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .flush(flush),
        .wbEnIn(wbEnIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn), .ldStatus(ldStatus), .imm(imm),
        .exeCmd(exeCmd), .val1(val1), .valRm(valRm), .pc(pc), .shifterOperand(shifterOperand),
        .signedImm24(signedImm24), .dest(dest), .selSrc1(selSrc1), .selSrc2(selSrc2),
        .valMem(valMem), .valWb(valWb), .outValid(outValid), .wbEnOut(wbEnOut),
        .memREnOut(memREnOut), .memWEnOut(memWEnOut), .aluRes(aluRes), .exeValRm(exeValRm),
        .branchAddr(branchAddr), .exeDest(exeDest), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwdModel(input logic [1:0] sel, input logic [31:0] r);
        case (sel)
            2'b00:   return r;
            2'b01:   return valMem;
            2'b10:   return valWb;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] val2Model(input bit mem, input bit immB, input logic [11:0] so,
                                              input logic [31:0] rm);
        logic [63:0]        dbl;
        int                 amt;
        int                 off;
        logic signed [31:0] srm;
        if (mem) begin
            off = $signed(so);
            return 32'(off);
        end
        if (immB) begin
            dbl = {24'd0, so[7:0], 24'd0, so[7:0]};
            amt = 2 * int'(so[11:8]);
            dbl = dbl >> amt;
            return dbl[31:0];
        end
        amt = int'(so[11:7]);
        case (so[6:5])
            2'b00: return rm << amt;
            2'b01: return rm >> amt;
            2'b10: begin
                srm = rm;
                return srm >>> amt;
            end
            default: begin
                dbl = {rm, rm};
                dbl = dbl >> amt;
                return dbl[31:0];
            end
        endcase
    endfunction

    // Arithmetic via 64-bit integers: carry is the unsigned result range, overflow the signed one
    task automatic aluModel(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] st, output logic [31:0] res,
                            output logic [3:0] nst, output bit known);
        longint ua, ub, sa, sb, u, s, cin;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cin = longint'(st[1]);
        nst = st;
        known = 1'b1;
        res = 32'd0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0010, 4'b0011: begin
                u = ua + ub + ((cmd == 4'b0011) ? cin : 0);
                s = sa + sb + ((cmd == 4'b0011) ? cin : 0);
                res = u[31:0];
                nst[1] = (u > 64'sd4294967295);
                nst[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                u = ua - ub - ((cmd == 4'b0101) ? (1 - cin) : 0);
                s = sa - sb - ((cmd == 4'b0101) ? (1 - cin) : 0);
                res = u[31:0];
                nst[1] = (u >= 0);
                nst[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: known = 1'b0;
        endcase
        if (known) begin
            nst[3] = res[31];
            nst[2] = (res == 32'd0);
        end
    endtask

    task automatic scramble();
        wbEnIn = 1'($urandom); memREnIn = 1'($urandom); memWEnIn = 1'($urandom);
        ldStatus = 1'($urandom); imm = 1'($urandom); exeCmd = 4'($urandom);
        val1 = $urandom; valRm = $urandom; pc = $urandom; valMem = $urandom; valWb = $urandom;
        shifterOperand = 12'($urandom); signedImm24 = 24'($urandom); dest = 4'($urandom);
        selSrc1 = 2'($urandom); selSrc2 = 2'($urandom);
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] rm,
                         input bit immB, input logic [11:0] so, input bit ld,
                         input logic [1:0] s1, input logic [1:0] s2, input bit memR, input bit memW);
        logic [31:0] s1v, rmv, v2, res, expBr;
        logic [3:0]  nst, expDest;
        logic        expWb;
        bit          known, isMul;
        int          lows, guard, off;
        scramble();
        exeCmd = cmd; val1 = v1; valRm = rm; imm = immB; shifterOperand = so; ldStatus = ld;
        selSrc1 = s1; selSrc2 = s2; memREnIn = memR; memWEnIn = memW;
        expWb = wbEnIn;
        expDest = dest;
        s1v = fwdModel(s1, v1);
        rmv = fwdModel(s2, rm);
        v2  = val2Model(memR || memW, immB, so, rmv);
`ifdef EXE_MLA_EN
        isMul = (cmd == 4'b1010) || (cmd == 4'b1011);
`else
        isMul = (cmd == 4'b1010);
`endif
        if (isMul) begin
            res = (cmd == 4'b1011) ? (rmv * v2 + s1v) : (s1v * v2);
            nst = expStatus;
            if (ld) begin
                nst[3] = res[31];
                nst[2] = (res == 32'd0);
            end
        end else begin
            aluModel(cmd, s1v, v2, expStatus, res, nst, known);
            if (!ld || !known) nst = expStatus;
        end
        off = $signed(signedImm24);
        expBr = pc + 32'(off * 4);
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        scramble();
        lows = 0;
        guard = 0;
        while (!outValid && guard < 200) begin
            if (!inReady) lows++;
            @(posedge clk);
            #1;
            guard++;
        end
        checkVal("commit_seen", 32'(outValid), 32'd1);
        checkVal("ready_low_cycles", 32'(lows), isMul ? 32'(N + 1) : 32'd0);
        checkVal("aluRes", aluRes, res);
        checkVal("status", 32'(status), 32'(nst));
        checkVal("exeDest", 32'(exeDest), 32'(expDest));
        checkVal("exeValRm", exeValRm, rmv);
        checkVal("branchAddr", branchAddr, expBr);
        checkVal("ctrl", 32'({wbEnOut, memREnOut, memWEnOut}), 32'({expWb, memR, memW}));
        checkVal("ready_after", 32'(inReady), 32'd1);
        expStatus = nst;
        lastRes = res;
        @(posedge clk);
        #1;
        checkVal("ov_single_pulse", 32'(outValid), 32'd0);
    endtask

    task automatic startMul();
        scramble();
        exeCmd = 4'b1010; val1 = 32'd9; valRm = 32'd9; imm = 1'b0; shifterOperand = 12'd0;
        selSrc1 = 2'b00; selSrc2 = 2'b00; memREnIn = 1'b0; memWEnIn = 1'b0; ldStatus = 1'b1;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    initial begin
        int anyOv;
        logic [3:0] cmd;
        flush = 1'b0;
        inValid = 1'b0;
        scramble();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_outValid", 32'(outValid), 32'd0);
        checkVal("rst_inReady", 32'(inReady), 32'd1);
        checkVal("rst_status", 32'(status), 32'd0);
        checkVal("rst_aluRes", aluRes, 32'd0);
        rst = 1'b0;
        expStatus = 4'd0;

        issue(4'b0010, 32'd5, 32'd0, 1'b1, 12'h003, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        checkVal("tp_add_res", aluRes, 32'd8);
        checkVal("tp_add_status", 32'(status), 32'b0000);

        issue(4'b0100, 32'd3, 32'd3, 1'b0, 12'h000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        checkVal("tp_sub_res", aluRes, 32'd0);
        checkVal("tp_sub_status", 32'(status), 32'b0110);

        issue(4'b1010, 32'd7, 32'd6, 1'b0, 12'h000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        checkVal("tp_mul_res", aluRes, 32'd42);
        checkVal("tp_mul_status", 32'(status), 32'b0010);

        issue(4'b1010, 32'hFFFF_FFFF, 32'd2, 1'b0, 12'h000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
        checkVal("tp_mul_neg_res", aluRes, 32'hFFFF_FFFE);
        checkVal("tp_mul_neg_status", 32'(status), 32'b1010);

        issue(4'b1011, 32'd10, 32'd3, 1'b1, 12'h004, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
`ifdef EXE_MLA_EN
        checkVal("tp_mla_res", aluRes, 32'd22);
        checkVal("tp_mla_status", 32'(status), 32'b0010);
`else
        checkVal("tp_mla_off_res", aluRes, 32'd0);
        checkVal("tp_mla_off_status", 32'(status), 32'b1010);
`endif

        // flush in the fifth MUL cycle with a competing instruction offered
        startMul();
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        inValid = 1'b1;
        exeCmd = 4'b0010;
        ldStatus = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        inValid = 1'b0;
        checkVal("flush_outValid", 32'(outValid), 32'd0);
        checkVal("flush_inReady", 32'(inReady), 32'd1);
        checkVal("flush_status", 32'(status), 32'(expStatus));
        anyOv = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (outValid) anyOv++;
        end
        checkVal("flush_no_commit", 32'(anyOv), 32'd0);
        checkVal("flush_res_hold", aluRes, lastRes);

        // reset in the middle of a multiply
        startMul();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkVal("rstmid_outValid", 32'(outValid), 32'd0);
        checkVal("rstmid_inReady", 32'(inReady), 32'd1);
        checkVal("rstmid_status", 32'(status), 32'd0);
        checkVal("rstmid_outs", aluRes | exeValRm | branchAddr, 32'd0);
        checkVal("rstmid_ctrl", 32'({wbEnOut, memREnOut, memWEnOut, exeDest}), 32'd0);
        expStatus = 4'd0;
        anyOv = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (outValid) anyOv++;
        end
        checkVal("rstmid_no_commit", 32'(anyOv), 32'd0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) cmd = ($urandom_range(0, 1) == 0) ? 4'b1010 : 4'b1011;
            else cmd = 4'($urandom);
            issue(cmd, $urandom, $urandom, 1'($urandom), 12'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
